// File: rtl/monster_fire_scheduler_pkg.sv
// Shared types and helpers for the enemy-fire scheduler and its arbiter.
package monster_fire_scheduler_pkg;

  typedef enum logic [1:0] {
    S_COOLDOWN,
    S_ARM,
    S_GRANT
  } fire_state_t;

  localparam int unsigned NUM_MONSTERS_DEF = 8;
  localparam int unsigned MONSTER_IDX_W    = $clog2(NUM_MONSTERS_DEF);

  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      c = c + {4'b0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/monster_fire_scheduler_if.sv
// Game-state side <-> scheduler signals; master = game logic, slave = scheduler.
interface monster_fire_scheduler_if #(
  parameter int unsigned N = 8
);
  logic         startOfFrame;
  logic         fire_enable;
  logic [N-1:0] alive;
  logic [N-1:0] shot_done;
  logic [N-1:0] fire_grant;
  logic [3:0]   inflight;
  logic         busy;

  modport master (
    output startOfFrame, fire_enable, alive, shot_done,
    input  fire_grant, inflight, busy
  );

  modport slave (
    input  startOfFrame, fire_enable, alive, shot_done,
    output fire_grant, inflight, busy
  );
endinterface

// File: rtl/monster_fire_scheduler_rr_arbiter.sv
// Combinational round-robin pick: scans ptr+1, ptr+2, ... and checks ptr itself last.
module rr_arbiter
  import monster_fire_scheduler_pkg::*;
#(
  parameter int unsigned N     = NUM_MONSTERS_DEF,
  parameter int unsigned IDX_W = MONSTER_IDX_W
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    cand       = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IDX_W'((32'(ptr) + i) % N);
      if (!any && req[cand]) begin
        any              = 1'b1;
        gnt_idx          = cand;
        gnt_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/monster_fire_scheduler.sv
// Shares the enemy-fire resource: one round-robin grant per cooldown, capped missiles in flight.
module monster_fire_scheduler
  import monster_fire_scheduler_pkg::*;
#(
  parameter int unsigned NUM_MONSTERS    = NUM_MONSTERS_DEF,
  parameter int unsigned COOLDOWN_FRAMES = 30,
  parameter int unsigned MAX_INFLIGHT    = 5,
  parameter int unsigned CNT_W           = 6
) (
  input  logic                     clk,
  input  logic                     resetN,
  monster_fire_scheduler_if.slave  bus
);

  localparam int unsigned IDX_W  = $clog2(NUM_MONSTERS);
  localparam logic [CNT_W-1:0] CD_INIT = CNT_W'(COOLDOWN_FRAMES);
  localparam logic [3:0]       MAX_IF  = 4'(MAX_INFLIGHT);

  fire_state_t             state_q, state_d;
  logic [CNT_W-1:0]        cd_q, cd_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        win_q, win_d;
  logic [NUM_MONSTERS-1:0] grant_q, grant_d;
  logic [3:0]              inflight_q, inflight_d;

  logic [NUM_MONSTERS-1:0] win_onehot;
  logic [IDX_W-1:0]        win_idx;
  logic                    win_any;
  logic [5:0]              up, pop, diff;

  rr_arbiter #(
    .N     (NUM_MONSTERS),
    .IDX_W (IDX_W)
  ) u_arb (
    .req        (bus.alive),
    .ptr        (ptr_q),
    .gnt_onehot (win_onehot),
    .gnt_idx    (win_idx),
    .any        (win_any)
  );

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    grant_d = '0;
    unique case (state_q)
      S_COOLDOWN: begin
        if (bus.startOfFrame) begin
          cd_d = cd_q - CNT_W'(1);
          if (cd_q == CNT_W'(1)) state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (bus.fire_enable && win_any && (inflight_q < MAX_IF)) begin
          grant_d = win_onehot;
          win_d   = win_idx;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        ptr_d   = win_q;
        cd_d    = CD_INIT;
        state_d = S_COOLDOWN;
      end
      default: state_d = S_COOLDOWN;
    endcase
  end

  // Launch and completions net in one step; clamp to [0, MAX_INFLIGHT].
  always_comb begin
    up   = 6'(inflight_q) + 6'(state_q == S_GRANT);
    pop  = {1'b0, popcount(16'(bus.shot_done))};
    diff = up - pop;
    if (pop >= up)               inflight_d = '0;
    else if (diff > 6'(MAX_IF))  inflight_d = MAX_IF;
    else                         inflight_d = diff[3:0];
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q    <= S_COOLDOWN;
      cd_q       <= CD_INIT;
      ptr_q      <= IDX_W'(NUM_MONSTERS - 1);
      win_q      <= '0;
      grant_q    <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      cd_q       <= cd_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      grant_q    <= grant_d;
      inflight_q <= inflight_d;
    end
  end

  assign bus.fire_grant = grant_q;
  assign bus.inflight   = inflight_q;
  assign bus.busy       = (state_q != S_ARM);

endmodule

// File: tb/tb_monster_fire_scheduler.sv
// Directed scenarios plus randomized traffic against a frame/queue-level reference model.
module tb_monster_fire_scheduler;

  localparam int N    = 8;
  localparam int COOL = 30;
  localparam int MAXI = 5;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  monster_fire_scheduler_if #(.N(N)) bus();

  monster_fire_scheduler #(
    .NUM_MONSTERS    (N),
    .COOLDOWN_FRAMES (COOL),
    .MAX_INFLIGHT    (MAXI),
    .CNT_W           (6)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: frames still to wait, armed flag, pending grant, last winner, missiles.
  int m_left  = COOL;
  bit m_armed = 1'b0;
  int m_grant = -1;
  int m_last  = N - 1;
  int m_infl  = 0;
  logic [N-1:0] m_alive_q = '0;

  function automatic int pick(input logic [N-1:0] a, input int last);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (a[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int nxt;
    if (!resetN) begin
      m_left = COOL; m_armed = 1'b0; m_grant = -1; m_last = N - 1; m_infl = 0;
    end else begin
      nxt = m_infl + ((m_grant >= 0) ? 1 : 0) - $countones(bus.shot_done);
      if (nxt < 0) nxt = 0;
      if (nxt > MAXI) nxt = MAXI;
      if (m_grant >= 0) begin
        m_last = m_grant; m_grant = -1; m_left = COOL;
      end else if (!m_armed) begin
        if (bus.startOfFrame) begin
          m_left--;
          if (m_left == 0) m_armed = 1'b1;
        end
      end else if (bus.fire_enable && bus.alive != '0 && m_infl < MAXI) begin
        m_grant   = pick(bus.alive, m_last);
        m_alive_q = bus.alive;
        m_armed   = 1'b0;
      end
      m_infl = nxt;
    end
  endtask

  task automatic tick();
    logic [N-1:0] eg;
    @(posedge clk);
    model_step();
    #1;
    eg = '0;
    if (m_grant >= 0) eg[m_grant] = 1'b1;
    check("grant", bus.fire_grant, eg);
    check("inflight", bus.inflight, m_infl);
    check("busy", bus.busy, !m_armed);
    check("grant_onehot0", $onehot0(bus.fire_grant), 1);
    check("grant_dead", bus.fire_grant & ~m_alive_q, 0);
    check("inflight_cap", bus.inflight <= MAXI, 1);
  endtask

  task automatic run_frames(input int n);
    for (int f = 0; f < n; f++) begin
      repeat ($urandom_range(0, 2)) tick();
      bus.startOfFrame = 1'b1;
      tick();
      bus.startOfFrame = 1'b0;
    end
  endtask

  task automatic wait_grant(output logic [N-1:0] g, output int lat);
    g = '0;
    lat = 0;
    while (lat < 200) begin
      tick();
      lat++;
      if (bus.fire_grant != '0) begin
        g = bus.fire_grant;
        break;
      end
    end
    check("grant_timeout", g != '0, 1);
  endtask

  task automatic expect_grant(input string tag, input logic [N-1:0] want);
    logic [N-1:0] g;
    int lat;
    wait_grant(g, lat);
    check(tag, g, want);
    check({tag, "_latency"}, lat, 1);
  endtask

  initial begin
    logic [N-1:0] exp_seq [4];
    bus.startOfFrame = 1'b0;
    bus.fire_enable  = 1'b0;
    bus.alive        = '0;
    bus.shot_done    = '0;

    // 1: reset, then first grant after COOL frames
    resetN = 1'b0;
    repeat (2) tick();
    check("rst_grant", bus.fire_grant, 0);
    check("rst_inflight", bus.inflight, 0);
    check("rst_busy", bus.busy, 1);
    resetN = 1'b1;
    bus.alive = 8'hFF;
    bus.fire_enable = 1'b1;
    run_frames(COOL);
    check("t1_armed", bus.busy, 0);
    expect_grant("t1_grant", 8'h01);
    tick();
    check("t1_inflight", bus.inflight, 1);

    // 2: round-robin up to the in-flight cap, then hold until a completion
    exp_seq = '{8'h02, 8'h04, 8'h08, 8'h10};
    for (int i = 0; i < 4; i++) begin
      run_frames(COOL);
      expect_grant("t2_grant", exp_seq[i]);
      tick();
    end
    check("t2_inflight_cap", bus.inflight, 5);
    run_frames(COOL);
    repeat (20) tick();
    check("t2_hold_busy", bus.busy, 0);
    check("t2_hold_grant", bus.fire_grant, 0);
    bus.shot_done = 8'h01;
    tick();
    bus.shot_done = '0;
    check("t2_done_dec", bus.inflight, 4);
    expect_grant("t2_after_done", 8'h20);
    tick();

    // 3: sparse alive mask, dead monsters skipped, pointer wraps
    bus.alive = 8'b1010_0000;
    bus.shot_done = 8'hFF;
    tick();
    bus.shot_done = '0;
    check("t3_sat_zero", bus.inflight, 0);
    run_frames(COOL); expect_grant("t3_w7", 8'h80); tick();
    run_frames(COOL); expect_grant("t3_w5", 8'h20); tick();
    run_frames(COOL); expect_grant("t3_w7b", 8'h80); tick();

    // 4: gate closed while armed
    bus.fire_enable = 1'b0;
    run_frames(COOL);
    run_frames(100);
    check("t4_busy", bus.busy, 0);
    check("t4_nogrant", bus.fire_grant, 0);
    bus.fire_enable = 1'b1;
    expect_grant("t4_grant", 8'h20);
    tick();
    check("t4_inflight", bus.inflight, 4);

    // 5: underflow protection and same-cycle grant+done
    bus.shot_done = 8'h07; tick();
    check("t5_dec3", bus.inflight, 1);
    bus.shot_done = 8'h03; tick();
    bus.shot_done = '0;
    check("t5_no_underflow", bus.inflight, 0);
    bus.alive = 8'hFF;
    run_frames(COOL); expect_grant("t5_g6", 8'h40); tick();
    check("t5_one", bus.inflight, 1);
    run_frames(COOL); expect_grant("t5_g7", 8'h80);
    bus.shot_done = 8'h01; tick();
    bus.shot_done = '0;
    check("t5_net", bus.inflight, 1);

    // 6: reset during the grant cycle
    run_frames(COOL);
    expect_grant("t6_pre", 8'h01);
    resetN = 1'b0;
    tick();
    check("t6_kill_grant", bus.fire_grant, 0);
    check("t6_inflight", bus.inflight, 0);
    resetN = 1'b1;
    run_frames(COOL - 1);
    check("t6_still_cool", bus.busy, 1);
    run_frames(1);
    check("t6_armed", bus.busy, 0);
    expect_grant("t6_grant", 8'h01);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bus.startOfFrame = ($urandom_range(0, 2) == 0);
      bus.fire_enable  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) bus.alive = N'($urandom);
      bus.shot_done = '0;
      if ($urandom_range(0, 5) == 0) bus.shot_done[$urandom_range(0, N - 1)] = 1'b1;
      if ($urandom_range(0, 19) == 0) bus.shot_done[$urandom_range(0, N - 1)] = 1'b1;
      resetN = ($urandom_range(0, 999) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
